// File: rtl/seg_display_scheduler.sv
// Scans four hex digits onto a common-anode 7-segment display with coherent frame
// snapshots, one-cycle anode dead time between digits, and optional whole-display blinking.
module seg_display_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_one,
    input  logic [3:0] digit_two,
    input  logic [3:0] digit_three,
    input  logic [3:0] digit_four,
    input  logic       one_en,
    input  logic       two_en,
    input  logic       three_en,
    input  logic       four_en,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0]     cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic [3:0][3:0]   snap_val_q, snap_val_d;
    logic [3:0]        snap_en_q, snap_en_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end;
    logic              frame_start;
    logic              blank;
    logic [3:0]        cur_val;
    logic              cur_en;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end    = (cnt_q == REFRESH_LAST);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        // Count 0 of index 0 is the first cycle of every frame, including right after reset.
        frame_start = (cnt_q == '0) && (idx_q == 2'd0);

        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_on_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_on_q : blink_on_q;

        snap_val_d = snap_val_q;
        snap_en_d  = snap_en_q;
        if (frame_start) begin
            snap_val_d = {digit_four, digit_three, digit_two, digit_one};
            snap_en_d  = {four_en, three_en, two_en, one_en};
        end

        cur_val = snap_val_q[idx_q];
        cur_en  = snap_en_q[idx_q];
        // Dead time also blanks seg so it only ever changes while all anodes are off.
        blank   = (cnt_q == '0) || !cur_en || (blink_en && !blink_on_q);

        an_d         = blank ? 4'b1111 : ~(4'b1000 >> idx_q);
        seg_d        = blank ? 7'b1111111 : hex_to_seg(cur_val);
        frame_tick_d = frame_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            snap_val_q   <= '0;
            snap_en_q    <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            snap_val_q   <= snap_val_d;
            snap_en_q    <= snap_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
